// File: rtl/rq_coeff_subtractor_if.sv
// Operand/result stream bundle for rq_coeff_subtractor.
// The neg lane exists only when RQ_SUB_NEGATE_EN is defined.
interface rq_coeff_subtractor_if #(
    parameter int NUM_WIDTH_LENGTH = 13
);
    logic                        in_valid;
    logic                        in_ready;
    logic [NUM_WIDTH_LENGTH-1:0] in1;
    logic [NUM_WIDTH_LENGTH-1:0] in2;
    logic                        out_valid;
    logic                        out_ready;
    logic [NUM_WIDTH_LENGTH-1:0] out;
    logic                        out_last;
`ifdef RQ_SUB_NEGATE_EN
    logic                        neg;
`endif

    modport master (
        output in_valid, in1, in2, out_ready,
        input  in_ready, out_valid, out, out_last
`ifdef RQ_SUB_NEGATE_EN
        , output neg
`endif
    );

    modport slave (
        input  in_valid, in1, in2, out_ready,
        output in_ready, out_valid, out, out_last
`ifdef RQ_SUB_NEGATE_EN
        , input neg
`endif
    );
endinterface

// File: rtl/rq_coeff_subtractor.sv
// Streaming Rq coefficient subtractor: (in1 - in2) mod 2^NUM_WIDTH_LENGTH, two-stage carry split.
// Define RQ_SUB_NEGATE_EN to add a per-coefficient neg lane that computes (in2 - in1) instead.
module rq_coeff_subtractor #(
    parameter int NUM_WIDTH_LENGTH = 13,
    parameter int N                = 701
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    rq_coeff_subtractor_if.slave bus
);
    localparam int LOW_W  = 8;
    localparam int HIGH_W = NUM_WIDTH_LENGTH - LOW_W;
    localparam int CNT_W  = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    state_t state;
    state_t state_next;

    logic [CNT_W-1:0]            in_cnt;
    logic                        s1_valid;
    logic                        s1_last;
    logic                        s1_c8;
    logic [LOW_W-1:0]            s1_low;
    logic [HIGH_W-1:0]           s1_a_hi;
    logic [HIGH_W-1:0]           s1_nb_hi;
    logic                        s2_valid;
    logic                        s2_last;
    logic [NUM_WIDTH_LENGTH-1:0] s2_data;

    logic                        s1_load;
    logic                        s2_load;
    logic                        accept;
    logic                        out_fire;
    logic [NUM_WIDTH_LENGTH-1:0] op_a;
    logic [NUM_WIDTH_LENGTH-1:0] op_nb;
    logic [LOW_W:0]              low_sum;
    logic [HIGH_W-1:0]           high_sum;

    // Stage 2 frees up on drain, so both stages can move in the same cycle.
    assign s2_load  = !s2_valid || bus.out_ready;
    assign s1_load  = s2_load || !s1_valid;
    assign out_fire = s2_valid && bus.out_ready;

    assign bus.in_ready = (state == RUN) && s1_load;
    assign accept       = bus.in_valid && bus.in_ready;

    // Swapping operands at the input lets neg ride along implicitly in the stage-1 operands.
`ifdef RQ_SUB_NEGATE_EN
    assign op_a  = bus.neg ? bus.in2 : bus.in1;
    assign op_nb = ~(bus.neg ? bus.in1 : bus.in2);
`else
    assign op_a  = bus.in1;
    assign op_nb = ~bus.in2;
`endif

    assign low_sum  = {1'b0, op_a[LOW_W-1:0]} + {1'b0, op_nb[LOW_W-1:0]} + (LOW_W+1)'(1);
    assign high_sum = s1_a_hi + s1_nb_hi + HIGH_W'(s1_c8);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        done       = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (accept && (in_cnt == LAST_IDX)) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (out_fire && s2_last) begin
                    state_next = IDLE;
                    done       = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            in_cnt <= '0;
        end else if (accept) begin
            in_cnt <= (in_cnt == LAST_IDX) ? '0 : in_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_c8    <= 1'b0;
            s1_low   <= '0;
            s1_a_hi  <= '0;
            s1_nb_hi <= '0;
        end else if (s1_load) begin
            s1_valid <= accept;
            if (accept) begin
                s1_last  <= (in_cnt == LAST_IDX);
                s1_c8    <= low_sum[LOW_W];
                s1_low   <= low_sum[LOW_W-1:0];
                s1_a_hi  <= op_a[NUM_WIDTH_LENGTH-1:LOW_W];
                s1_nb_hi <= op_nb[NUM_WIDTH_LENGTH-1:LOW_W];
            end
        end
    end

    // Data only updates on a real entry, so out holds its last value while stalled or empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_last  <= 1'b0;
            s2_data  <= '0;
        end else if (s2_load) begin
            s2_valid <= s1_valid;
            s2_last  <= s1_valid && s1_last;
            if (s1_valid) begin
                s2_data <= {high_sum, s1_low};
            end
        end
    end

    assign bus.out_valid = s2_valid;
    assign bus.out       = s2_data;
    assign bus.out_last  = s2_last;
endmodule

// File: tb/tb_rq_coeff_subtractor.sv
// Bench for rq_coeff_subtractor: N=4 table job on a small instance, scoreboarded N=701 jobs on the main one.
module tb_rq_coeff_subtractor;
    localparam int W  = 13;
    localparam int N  = 701;
    localparam int NS = 4;

    typedef struct {
        logic [W-1:0] data;
        logic         last;
    } exp_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         ng;
        logic [W-1:0] expv;
        logic         last;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic start, busy, done;
    logic s_start, s_busy, s_done;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    exp_t exp_q[$];
    exp_t mon_e;
    logic mon_exp_done;
    logic cur_neg;
    bit   mon_en = 1'b0;
    bit   in_fire = 1'b0;
    int   tb_in_idx = 0;
    int   done_cnt = 0;
    int   out_cnt = 0;
    int   first_out_cyc = 0;
    int   last_out_cyc = 0;
    bit   hold_pending = 1'b0;
    logic [W-1:0] hold_data;
    logic hold_last;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    rq_coeff_subtractor_if #(.NUM_WIDTH_LENGTH(W)) bus ();
    rq_coeff_subtractor_if #(.NUM_WIDTH_LENGTH(W)) sbus ();

    rq_coeff_subtractor #(.NUM_WIDTH_LENGTH(W), .N(N)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .bus(bus)
    );

    rq_coeff_subtractor #(.NUM_WIDTH_LENGTH(W), .N(NS)) sdut (
        .clk(clk), .rst(rst), .start(s_start), .busy(s_busy), .done(s_done), .bus(sbus)
    );

`ifdef RQ_SUB_NEGATE_EN
    assign cur_neg = bus.neg;
`else
    assign cur_neg = 1'b0;
`endif

    function automatic logic [W-1:0] model_sub(input logic [W-1:0] a, input logic [W-1:0] b, input logic ng);
        logic [W-1:0] r;
        r = ng ? (b - a) : (a - b);
        return r;
    endfunction

    task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("[TB] FAIL %s got %0h expected %0h", name, got, expv);
        end
    endtask

    task automatic new_pair();
        bus.in1 = W'($urandom);
        bus.in2 = W'($urandom);
`ifdef RQ_SUB_NEGATE_EN
        bus.neg = 1'($urandom_range(1));
`endif
    endtask

    // Scoreboard: push on input handshake, pop and compare on output handshake.
    always @(negedge clk) begin
        in_fire = 1'b0;
        if (!rst && mon_en) begin
            mon_exp_done = 1'b0;
            if (hold_pending) begin
                check_output("hold_valid", bus.out_valid, 1);
                check_output("hold_data", bus.out, hold_data);
                check_output("hold_last", bus.out_last, hold_last);
            end
            if (!busy) check_output("idle_in_ready", bus.in_ready, 0);
            if (bus.in_valid && bus.in_ready) begin
                in_fire = 1'b1;
                exp_q.push_back('{model_sub(bus.in1, bus.in2, cur_neg), tb_in_idx == N - 1});
                tb_in_idx = (tb_in_idx == N - 1) ? 0 : tb_in_idx + 1;
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_out got %0h expected none", bus.out);
                end else begin
                    mon_e = exp_q.pop_front();
                    check_output("out_data", bus.out, mon_e.data);
                    check_output("out_last", bus.out_last, mon_e.last);
                    mon_exp_done = mon_e.last;
                    if (out_cnt == 0) first_out_cyc = cyc;
                    if (mon_e.last) last_out_cyc = cyc;
                    out_cnt++;
                end
            end
            check_output("done", done, mon_exp_done);
            if (done) done_cnt++;
            hold_pending = bus.out_valid && !bus.out_ready;
            hold_data    = bus.out;
            hold_last    = bus.out_last;
        end else begin
            hold_pending = 1'b0;
        end
    end

    // Runs one job on the main DUT; restart_at re-pulses start mid-job, abort_at resets after that many inputs.
    task automatic apply_stimulus(input int valid_pct, input int ready_pct, input int restart_at,
                                  input int abort_at, input bit check_timing);
        int sent;
        int guard;
        int done_base;
        int start_c;
        sent      = 0;
        guard     = 0;
        done_base = done_cnt;
        out_cnt   = 0;
        @(posedge clk); #1;
        start         = 1'b1;
        start_c       = cyc;
        new_pair();
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        while (done_cnt == done_base && guard < 20000) begin
            if (in_fire) begin
                sent++;
                new_pair();
            end
            if (abort_at >= 0 && sent == abort_at) break;
            bus.in_valid  = (sent < N) && ($urandom_range(99) < valid_pct);
            bus.out_ready = $urandom_range(99) < ready_pct;
            start         = (sent == restart_at);
            guard++;
            @(posedge clk); #1;
        end
        start = 1'b0;
        if (guard >= 20000) begin
            checks++;
            errors++;
            $display("[TB] FAIL job_timeout got %0d outputs expected %0d", out_cnt, N);
        end else if (abort_at >= 0) begin
            rst          = 1'b1;
            bus.in_valid = 1'b0;
            @(posedge clk); #1;
            check_output("abort_in_ready", bus.in_ready, 0);
            check_output("abort_out_valid", bus.out_valid, 0);
            check_output("abort_out", bus.out, 0);
            check_output("abort_out_last", bus.out_last, 0);
            check_output("abort_busy", busy, 0);
            check_output("abort_done", done, 0);
            exp_q.delete();
            tb_in_idx = 0;
            rst = 1'b0;
        end else begin
            check_output("queue_empty", exp_q.size(), 0);
            check_output("out_count", out_cnt, N);
            if (check_timing) begin
                check_output("first_out_latency", first_out_cyc - start_c, 3);
                check_output("last_out_latency", last_out_cyc - start_c, N + 2);
            end
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
    endtask

    task automatic drive_small(input vec_t v);
        sbus.in1 = v.a;
        sbus.in2 = v.b;
`ifdef RQ_SUB_NEGATE_EN
        sbus.neg = v.ng;
`endif
    endtask

    // N=4 job from a vector table; checks data, last and the done pulse per output.
    task automatic run_small_table();
        vec_t vecs[NS];
        int in_i;
        int out_i;
        int dones;
        bit fire;
        in_i  = 0;
        out_i = 0;
        dones = 0;
`ifdef RQ_SUB_NEGATE_EN
        vecs[0] = '{13'h0003, 13'h0005, 1'b1, 13'h0002, 1'b0};
        vecs[1] = '{13'h0003, 13'h0005, 1'b0, 13'h1FFE, 1'b0};
        vecs[2] = '{13'h1000, 13'h1FFF, 1'b1, 13'h0FFF, 1'b0};
        vecs[3] = '{13'h1FFF, 13'h0000, 1'b0, 13'h1FFF, 1'b1};
`else
        vecs[0] = '{13'h0005, 13'h0003, 1'b0, 13'h0002, 1'b0};
        vecs[1] = '{13'h0000, 13'h0001, 1'b0, 13'h1FFF, 1'b0};
        vecs[2] = '{13'h1000, 13'h1FFF, 1'b0, 13'h1001, 1'b0};
        vecs[3] = '{13'h1FFF, 13'h0000, 1'b0, 13'h1FFF, 1'b1};
`endif
        sbus.out_ready = 1'b1;
        @(posedge clk); #1;
        s_start = 1'b1;
        @(posedge clk); #1;
        s_start       = 1'b0;
        sbus.in_valid = 1'b1;
        drive_small(vecs[0]);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            fire = sbus.in_valid && sbus.in_ready;
            if (sbus.out_valid) begin
                if (out_i < NS) begin
                    check_output("small_out", sbus.out, vecs[out_i].expv);
                    check_output("small_last", sbus.out_last, vecs[out_i].last);
                    check_output("small_done", s_done, vecs[out_i].last);
                    out_i++;
                end else begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL small_extra_out got %0h expected none", sbus.out);
                end
            end else begin
                check_output("small_done_idle", s_done, 0);
            end
            if (s_done) dones++;
            @(posedge clk); #1;
            if (fire) begin
                in_i++;
                if (in_i < NS) drive_small(vecs[in_i]);
                else sbus.in_valid = 1'b0;
            end
        end
        check_output("small_in_count", in_i, NS);
        check_output("small_out_count", out_i, NS);
        check_output("small_done_pulses", dones, 1);
        check_output("small_busy_end", s_busy, 0);
    endtask

    initial begin
        rst            = 1'b1;
        start          = 1'b0;
        s_start        = 1'b0;
        bus.in_valid   = 1'b0;
        bus.in1        = '0;
        bus.in2        = '0;
        bus.out_ready  = 1'b1;
        sbus.in_valid  = 1'b0;
        sbus.in1       = '0;
        sbus.in2       = '0;
        sbus.out_ready = 1'b1;
`ifdef RQ_SUB_NEGATE_EN
        bus.neg  = 1'b0;
        sbus.neg = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check_output("rst_in_ready", bus.in_ready, 0);
        check_output("rst_out_valid", bus.out_valid, 0);
        check_output("rst_out", bus.out, 0);
        check_output("rst_out_last", bus.out_last, 0);
        check_output("rst_busy", busy, 0);
        check_output("rst_done", done, 0);
        check_output("rst_s_out_valid", sbus.out_valid, 0);
        check_output("rst_s_busy", s_busy, 0);
        rst    = 1'b0;
        mon_en = 1'b1;

        $display("[TB] in_valid while idle");
        bus.in_valid = 1'b1;
        new_pair();
        repeat (5) @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check_output("idle_no_accept", exp_q.size(), 0);

        $display("[TB] N=4 table job");
        run_small_table();
        $display("[TB] full job, no stalls");
        apply_stimulus(100, 100, -1, -1, 1'b1);
        $display("[TB] full job, random stalls");
        apply_stimulus(70, 50, -1, -1, 1'b0);
        $display("[TB] start re-asserted during RUN");
        apply_stimulus(80, 80, 300, -1, 1'b0);
        $display("[TB] reset after 10 inputs");
        apply_stimulus(100, 100, -1, 10, 1'b0);
        $display("[TB] clean job after reset");
        apply_stimulus(100, 100, -1, -1, 1'b1);

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
